// File: rtl/hydra_fetch_pkg.sv
// Shared opcode constants, fetch FSM states and the decoded-instruction record
// for the instruction fetch unit and its optional prefetch queue.
package hydra_fetch_pkg;
  localparam logic [4:0] OP_MOVR    = 5'b11010;
  localparam logic [4:0] OP_MOV     = 5'b11000;
  localparam int         INST_BYTES = 4;
  localparam int         PC_W       = 16;

  typedef enum logic [2:0] {IDLE, FETCH_W1, FETCH_W2, HOLD_WAIT, HOLD} fetch_state_e;

  typedef struct packed {
    logic [15:0]     inst1;
    logic [15:0]     inst2;
    logic [PC_W-1:0] pc;
  } inst_t;

  // MOVR becomes MOV with the absolute return-style immediate pc+4, so decode never sees MOVR.
  function automatic inst_t movr_rewrite(input logic [15:0] w1, input logic [15:0] w2,
                                         input logic [PC_W-1:0] pc);
    inst_t r;
    r.pc    = pc;
    r.inst1 = w1;
    r.inst2 = w2;
    if (w1[15:11] == OP_MOVR) begin
      r.inst1[15:11] = OP_MOV;
      r.inst2        = 16'(pc + PC_W'(INST_BYTES));
    end
    return r;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO used only when FETCH_PREFETCH_EN is defined;
// entry 0 is always the head, so pop is a simple shift.
module fetch_queue
  import hydra_fetch_pkg::*;
#(
  parameter inst_t RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  inst_t      din,
  output inst_t      head,
  output logic [1:0] count
);
  inst_t      ent0_q, ent1_q;
  logic [1:0] cnt_q;
  logic       pop_ok, push_ok;

  assign pop_ok  = pop && (cnt_q != 2'd0);
  assign push_ok = push && ((cnt_q != 2'd2) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      ent0_q <= RESET_VAL;
      ent1_q <= RESET_VAL;
    end else if (flush) begin
      cnt_q <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= din;
          else               ent1_q <= din;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_q <= din;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = ent0_q;
  assign count = cnt_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Two-word instruction fetch with MOVR rewrite and PC redirect.
// FETCH_PREFETCH_EN selects a 2-entry prefetch queue instead of a single holding register.
module instruction_fetch_unit
  import hydra_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [15:0]       inst1,
  output logic [15:0]       inst2,
  output logic [ADDR_W-1:0] inst_pc
);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] INST_STEP = ADDR_W'(INST_BYTES);
  localparam inst_t             INST_RST  = '{inst1: 16'h0, inst2: 16'h0, pc: PC_W'(RESET_PC)};

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       w1_q, w1_d;
  logic              accept, push, room;
  inst_t             cap;

  assign accept = inst_valid && inst_ready;
  assign cap    = movr_rewrite(w1_q, mem_rdata, PC_W'(pc_q));

`ifdef FETCH_PREFETCH_EN
  inst_t      q_head;
  logic [1:0] q_cnt;
  logic       room_after_push;

  assign room            = (q_cnt != 2'd2) || accept;
  assign room_after_push = (q_cnt == 2'd0) || ((q_cnt == 2'd1) && accept);

  fetch_queue #(.RESET_VAL(INST_RST)) u_queue (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (accept),
    .din   (cap),
    .head  (q_head),
    .count (q_cnt)
  );

  assign inst_valid = (q_cnt != 2'd0);
  assign inst1      = q_head.inst1;
  assign inst2      = q_head.inst2;
  assign inst_pc    = ADDR_W'(q_head.pc);
`else
  inst_t out_q;
  logic  vld_q;

  assign room = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= INST_RST;
      vld_q <= 1'b0;
    end else if (redirect) begin
      vld_q <= 1'b0;
    end else if (push) begin
      out_q <= cap;
      vld_q <= 1'b1;
    end else if (accept) begin
      vld_q <= 1'b0;
    end
  end

  assign inst_valid = vld_q;
  assign inst1      = out_q.inst1;
  assign inst2      = out_q.inst2;
  assign inst_pc    = ADDR_W'(out_q.pc);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      w1_q    <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      w1_q    <= w1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    w1_d      = w1_q;
    mem_rd_en = 1'b0;
    mem_addr  = pc_q;
    push      = 1'b0;
    case (state_q)
      IDLE: if (!halt && room) state_d = FETCH_W1;
      FETCH_W1: begin
        mem_rd_en = 1'b1;
        state_d   = FETCH_W2;
      end
      FETCH_W2: begin
        mem_rd_en = 1'b1;
        mem_addr  = pc_q + WORD_STEP;
        w1_d      = mem_rdata;
        state_d   = HOLD_WAIT;
      end
      HOLD_WAIT: begin
        push = 1'b1;
`ifdef FETCH_PREFETCH_EN
        // Overlap the next word-1 read with this capture to reach one instruction per two cycles.
        pc_d = pc_q + INST_STEP;
        if (!halt && room_after_push) begin
          mem_rd_en = 1'b1;
          mem_addr  = pc_q + INST_STEP;
          state_d   = FETCH_W2;
        end else begin
          state_d = HOLD;
        end
`else
        state_d = HOLD;
`endif
      end
      HOLD: begin
`ifdef FETCH_PREFETCH_EN
        if (!halt && room) state_d = FETCH_W1;
`else
        if (accept) begin
          pc_d    = pc_q + INST_STEP;
          state_d = halt ? IDLE : FETCH_W1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      pc_d    = {redirect_pc[ADDR_W-1:1], 1'b0};
      state_d = FETCH_W1;
      push    = 1'b0;
    end
  end
endmodule
